// File: rtl/stack_alu_pkg.sv
// Shared opcode encoding for the stack ALU datapath.
package stack_alu_pkg;

  typedef logic [2:0] opcode_t;

  // Any opcode with bit 2 clear is a NOP.
  localparam opcode_t OP_ADD  = 3'b100;
  localparam opcode_t OP_MUL  = 3'b101;
  localparam opcode_t OP_PUSH = 3'b110;
  localparam opcode_t OP_POP  = 3'b111;

  function automatic logic is_nop(opcode_t op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/stack_alu_lifo.sv
// Register-array LIFO with combinational top and next-to-top read ports.
module stack_alu_lifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] push_data_i,
  output logic [Width-1:0] top_o,
  output logic [Width-1:0] next_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [CntW-1:0]  count_q, count_d;
  logic [IdxW-1:0]  top_idx, next_idx;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Read indices are clamped to 0 when the stack is too shallow; data is then unused.
  always_comb begin
    top_idx  = '0;
    next_idx = '0;
    if (count_q >= CntW'(1)) top_idx  = IdxW'(count_q - CntW'(1));
    if (count_q >= CntW'(2)) next_idx = IdxW'(count_q - CntW'(2));
  end

  assign top_o  = mem_q[top_idx];
  assign next_o = mem_q[next_idx];

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Contents need no reset: nothing is readable until pushed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[count_q[IdxW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/stack_alu.sv
// Stack ALU: opcode decode, signed add/multiply with overflow, registered result.
module stack_alu
  import stack_alu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] input_data,
  output logic [N-1:0] output_data,
  output logic         overflow
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  opcode_t          op;
  logic             push, pop, full, empty, has_two;
  logic [N-1:0]     top, next, sum;
  logic [CntW-1:0]  count;
  logic [2*N-1:0]   prod;
  logic             add_ovf, mul_ovf;
  logic [N-1:0]     out_q, out_d;
  logic             ovf_q, ovf_d;

  assign op = opcode_t'(opcode);

  stack_alu_lifo #(
    .Width (N),
    .Depth (DEPTH)
  ) u_lifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (input_data),
    .top_o       (top),
    .next_o      (next),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign has_two = (count >= CntW'(2));
  assign sum     = top + next;
  assign add_ovf = (top[N-1] == next[N-1]) && (sum[N-1] != top[N-1]);
  // Sign-extend to 2N so the low 2N bits of the product are the exact signed result.
  assign prod    = $signed({{N{top[N-1]}}, top}) * $signed({{N{next[N-1]}}, next});
  assign mul_ovf = (prod[2*N-1:N] != {N{prod[N-1]}});

  always_comb begin
    out_d = out_q;
    ovf_d = ovf_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (!is_nop(op)) begin
      case (op)
        OP_PUSH: begin
          if (!full) begin
            push  = 1'b1;
            ovf_d = 1'b0;
          end
        end
        OP_POP: begin
          pop   = 1'b1;
          out_d = empty ? '0 : top;
          ovf_d = 1'b0;
        end
        OP_ADD: begin
          if (has_two) begin
            out_d = sum;
            ovf_d = add_ovf;
          end
        end
        OP_MUL: begin
          if (has_two) begin
            out_d = prod[N-1:0];
            ovf_d = mul_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign output_data = out_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_stack_alu.sv
// Directed bench for stack_alu with an expected-result queue checked after each edge.
module tb_stack_alu;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic [7:0] input_data;
  logic [7:0] output_data;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] out;
    logic       ovf;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  stack_alu #(
    .N     (8),
    .DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .input_data  (input_data),
    .output_data (output_data),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish required=finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed out=%h ovf=%b required out=%h ovf=%b",
             tag, obs[8:1], obs[0], exp[8:1], exp[0]);
    end
  endtask

  // Queue the expectation, drive the opcode, then compare just after the sampling edge.
  task automatic step(input string tag, input logic [2:0] op, input logic [7:0] din,
                      input logic [7:0] exp_out, input logic exp_ovf);
    exp_t  e;
    string t;
    sb_q.push_back('{out: exp_out, ovf: exp_ovf});
    tag_q.push_back(tag);
    @(negedge clk);
    opcode     = op;
    input_data = din;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check(t, {output_data, overflow}, {e.out, e.ovf});
  endtask

  initial begin
    rst_n      = 1'b0;
    opcode     = NOP;
    input_data = '0;
    #12;
    check("reset", {output_data, overflow}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;

    step("pop_empty",   POP,  8'h00, 8'h00, 1'b0);
    step("push10",      PUSH, 8'd10, 8'h00, 1'b0);
    step("push20",      PUSH, 8'd20, 8'h00, 1'b0);
    step("add_30",      ADD,  8'h00, 8'd30, 1'b0);
    step("add_nondest", ADD,  8'h00, 8'd30, 1'b0);
    step("push3",       PUSH, 8'd3,  8'd30, 1'b0);
    step("push4",       PUSH, 8'd4,  8'd30, 1'b0);
    step("mul_12",      MUL,  8'h00, 8'd12, 1'b0);
    step("nop_hold",    NOP,  8'hAA, 8'd12, 1'b0);
    step("pop_4",       POP,  8'h00, 8'd4,  1'b0);
    step("push7f",      PUSH, 8'h7F, 8'd4,  1'b0);
    step("push1",       PUSH, 8'h01, 8'd4,  1'b0);
    step("add_ovf",     ADD,  8'h00, 8'h80, 1'b1);
    step("push_clr",    PUSH, 8'h80, 8'h80, 1'b0);
    step("push2",       PUSH, 8'h02, 8'h80, 1'b0);
    step("mul_ovf",     MUL,  8'h00, 8'h00, 1'b1);
    // Stack now holds 7 entries; this push fills it.
    step("push_full",   PUSH, 8'h55, 8'h00, 1'b0);
    step("mul_55x2",    MUL,  8'h00, 8'hAA, 1'b1);
    step("push_ignore", PUSH, 8'h66, 8'hAA, 1'b1);
    step("pop_55",      POP,  8'h00, 8'h55, 1'b0);
    step("pop_02",      POP,  8'h00, 8'h02, 1'b0);
    step("pop_80",      POP,  8'h00, 8'h80, 1'b0);
    step("pop_01",      POP,  8'h00, 8'h01, 1'b0);
    step("pop_7f",      POP,  8'h00, 8'h7F, 1'b0);
    step("pop_03",      POP,  8'h00, 8'h03, 1'b0);
    step("pop_20",      POP,  8'h00, 8'd20, 1'b0);
    step("add_one",     ADD,  8'h00, 8'd20, 1'b0);
    step("mul_one",     MUL,  8'h00, 8'd20, 1'b0);
    step("pop_10",      POP,  8'h00, 8'd10, 1'b0);
    step("pop_empty2",  POP,  8'h00, 8'h00, 1'b0);

    step("push_m5",     PUSH, 8'hFB, 8'h00, 1'b0);
    step("push_m3",     PUSH, 8'hFD, 8'h00, 1'b0);
    step("add_neg",     ADD,  8'h00, 8'hF8, 1'b0);
    step("mul_neg",     MUL,  8'h00, 8'h0F, 1'b0);
    step("push_m128",   PUSH, 8'h80, 8'h0F, 1'b0);
    step("push_m1",     PUSH, 8'hFF, 8'h0F, 1'b0);
    step("add_negovf",  ADD,  8'h00, 8'h7F, 1'b1);
    step("mul_m128xm1", MUL,  8'h00, 8'h80, 1'b1);

    // Asynchronous reset in mid-cycle must clear outputs without a clock edge.
    @(negedge clk);
    opcode = NOP;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {output_data, overflow}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    step("pop_after_rst", POP,  8'h00, 8'h00, 1'b0);
    step("push_after",    PUSH, 8'h21, 8'h00, 1'b0);
    step("add_after_one", ADD,  8'h00, 8'h00, 1'b0);
    step("pop_21",        POP,  8'h00, 8'h21, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
